// File: rtl/trace_lane_arbiter.sv
// trace_lane_arbiter: buffers two retirement-trace lanes in FIFOs and merges them round-robin onto one valid/ready sink
module trace_lane_arbiter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      clear_drops,
   input  logic                      in_0_valid,
   input  logic [39:0]               in_0_iaddr,
   input  logic [31:0]               in_0_insn,
   input  logic [2:0]                in_0_priv,
   input  logic                      in_0_exception,
   input  logic                      in_0_interrupt,
   input  logic [63:0]               in_0_cause,
   input  logic [39:0]               in_0_tval,
   input  logic                      in_1_valid,
   input  logic [39:0]               in_1_iaddr,
   input  logic [31:0]               in_1_insn,
   input  logic [2:0]                in_1_priv,
   input  logic                      in_1_exception,
   input  logic                      in_1_interrupt,
   input  logic [63:0]               in_1_cause,
   input  logic [39:0]               in_1_tval,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_lane,
   output logic [39:0]               out_iaddr,
   output logic [31:0]               out_insn,
   output logic [2:0]                out_priv,
   output logic                      out_exception,
   output logic                      out_interrupt,
   output logic [63:0]               out_cause,
   output logic [39:0]               out_tval,
   output logic [$clog2(DEPTH):0]    occ_0,
   output logic [$clog2(DEPTH):0]    occ_1,
   output logic [CNT_W-1:0]          drops_0,
   output logic [CNT_W-1:0]          drops_1
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = 181;
   logic [DW-1:0]    in_pkt [2];
   logic [DW-1:0]    mem [2][DEPTH];
   logic [AW-1:0]    wp [2];
   logic [AW-1:0]    rp [2];
   logic [AW:0]      occ [2];
   logic [CNT_W-1:0] drops [2];
   logic [1:0]       in_v, ne, full, push, drop, pop;
   logic             lock, lock_lane, last_grant, grant;
   assign in_pkt[0] = {in_0_iaddr, in_0_insn, in_0_priv, in_0_exception, in_0_interrupt, in_0_cause, in_0_tval};
   assign in_pkt[1] = {in_1_iaddr, in_1_insn, in_1_priv, in_1_exception, in_1_interrupt, in_1_cause, in_1_tval};
   assign in_v      = {in_1_valid, in_0_valid};
   assign occ_0     = occ[0];
   assign occ_1     = occ[1];
   assign drops_0   = drops[0];
   assign drops_1   = drops[1];
   // fullness from start-of-cycle occupancy; grant is frozen while locked, otherwise round-robin
   always_comb begin
      ne        = {occ[1] != '0, occ[0] != '0};
      full      = {occ[1] == (AW+1)'(DEPTH), occ[0] == (AW+1)'(DEPTH)};
      push      = in_v & {2{enable}} & ~full;
      drop      = in_v & {2{enable}} & full;
      grant     = lock ? lock_lane : (&ne) ? ~last_grant : ne[1];
      out_valid = lock | (|ne);
      out_lane  = grant;
      pop       = (out_valid & out_ready) ? (grant ? 2'b10 : 2'b01) : 2'b00;
      {out_iaddr, out_insn, out_priv, out_exception, out_interrupt, out_cause, out_tval} = mem[grant][rp[grant]];
   end
   // FIFO storage needs no reset; stale entries are unreachable once pointers clear
   always_ff @(posedge clock) begin
      for (int n = 0; n < 2; n++)
         if (push[n]) mem[n][wp[n]] <= in_pkt[n];
   end
   // pointers, occupancy, saturating drop counters and arbitration state
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int n = 0; n < 2; n++) begin
            wp[n]    <= '0;
            rp[n]    <= '0;
            occ[n]   <= '0;
            drops[n] <= '0;
         end
         lock       <= 1'b0;
         lock_lane  <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (push[n]) wp[n] <= wp[n] + AW'(1);
            if (pop[n]) rp[n] <= rp[n] + AW'(1);
            occ[n]   <= occ[n] + (AW+1)'(push[n]) - (AW+1)'(pop[n]);
            drops[n] <= clear_drops ? '0 : (drop[n] && !(&drops[n])) ? drops[n] + CNT_W'(1) : drops[n];
         end
         if (out_valid && out_ready) begin
            lock       <= 1'b0;
            last_grant <= grant;
         end else if (out_valid) begin
            lock      <= 1'b1;
            lock_lane <= grant;
         end
      end
   end
endmodule
